// File: rtl/fib_pkg.sv
// Shared types and ALU control encodings for the recursive Fibonacci sequencer.
package fib_pkg;

  localparam int NW = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    POP,
    EVAL,
    PUSH2,
    DONE
  } state_t;

  typedef struct packed {
    logic ins;
    logic modes;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_LOAD = '{ins: 1'b1, modes: 1'b0};
  localparam alu_ctrl_t ALU_DEC1 = '{ins: 1'b0, modes: 1'b0};
  localparam alu_ctrl_t ALU_DEC2 = '{ins: 1'b0, modes: 1'b1};

endpackage

// File: rtl/fib_stack_ctrl_if.sv
// Request/result handshake plus the ALU control/result lines of the Fibonacci sequencer.
interface fib_stack_ctrl_if #(parameter int W = 8);
  import fib_pkg::*;

  logic          start;
  logic [NW-1:0] n;
  logic [NW-1:0] dec;
  logic          lt;
  logic [NW-1:0] ts;
  logic          ins;
  logic          modes;
  logic [W-1:0]  result;
  logic          busy;
  logic          done;
  logic          overflow;

  modport master (
    output start, n, dec, lt,
    input  ts, ins, modes, result, busy, done, overflow
  );

  modport slave (
    input  start, n, dec, lt,
    output ts, ins, modes, result, busy, done, overflow
  );

endinterface

// File: rtl/fib_stack.sv
// DEPTH x 3-bit LIFO: synchronous push/pop, combinational top-of-stack.
module fib_stack
  import fib_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [NW-1:0]                din,
  output logic [NW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_m1;

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - 1'b1;
  assign top   = empty ? '0 : mem[sp_m1[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Storage needs no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[sp[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fib_stack_ctrl.sv
// Sequencer for the recursive 3-bit Fibonacci datapath: explicit call stack,
// running accumulator, Moore ALU controls (ins/modes) fed to an external ALU.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | ALU passes n through; n becomes the root stack entry
// POP   | top of stack moves into ts
// EVAL  | leaf (ts<2): accumulate; else push ts-1
// PUSH2 | push ts-2 so it is evaluated first
// DONE  | one-cycle done pulse; result captured at the closing edge
module fib_stack_ctrl
  import fib_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  fib_stack_ctrl_if.slave bus
);

  localparam int SPW = $clog2(DEPTH + 1);

  state_t          state;
  alu_ctrl_t       ctrl;
  logic [NW-1:0]   ts;
  logic [W-1:0]    acc;
  logic [W-1:0]    result;
  logic            busy;
  logic            done;
  logic            overflow;

  logic            clr;
  logic            push;
  logic            pop;
  logic            push_blocked;
  logic [NW-1:0]   stk_top;
  logic [SPW-1:0]  sp;
  logic            full;
  logic            empty;

  assign clr          = (state == IDLE) && bus.start;
  assign push         = (state == LOAD) || ((state == EVAL) && !bus.lt) || (state == PUSH2);
  assign pop          = (state == POP) && !empty;
  assign push_blocked = push && full;

  fib_stack #(.DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (bus.dec),
    .top   (stk_top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctrl     <= ALU_DEC1;
      ts       <= '0;
      acc      <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD;
            ctrl     <= ALU_LOAD;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          acc   <= '0;
          state <= POP;
          ctrl  <= ALU_DEC1;
        end
        POP: begin
          ts    <= stk_top;
          state <= EVAL;
        end
        EVAL: begin
          if (bus.lt) begin
            acc <= acc + W'(ts);
            if (sp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= POP;
            end
          end else if (push_blocked) begin
            overflow <= 1'b1;
            state    <= DONE;
            done     <= 1'b1;
          end else begin
            state <= PUSH2;
            ctrl  <= ALU_DEC2;
          end
        end
        PUSH2: begin
          ctrl <= ALU_DEC1;
          // A blocked push abandons the walk; result keeps the partial sum.
          if (push_blocked) begin
            overflow <= 1'b1;
            state    <= DONE;
            done     <= 1'b1;
          end else begin
            state <= POP;
          end
        end
        DONE: begin
          result <= acc;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          ctrl  <= ALU_DEC1;
        end
      endcase
    end
  end

  assign bus.ts       = ts;
  assign bus.ins      = ctrl.ins;
  assign bus.modes    = ctrl.modes;
  assign bus.result   = result;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = overflow;

endmodule
